snitch_vfpr_mp: RTL and testbench

SNITCH_VFPR_MP -- requirements
Module: snitch_vfpr_mp

---
 rtl/snitch_vfpr_mp.sv | 164 ++++++++++++++++
 tb/tb_snitch_vfpr_mp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/snitch_vfpr_mp.sv
// snitch_vfpr_mp: multi-port FP register read bundler with in-order completion; define SNITCH_VFPR_MP_FWD_EN for write-to-read forwarding
module snitch_vfpr_mp #(
  parameter int unsigned NumReadPorts   = 3,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         tag_t          = logic
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
  input  logic [NumReadPorts-1:0]           ren_i,
  input  tag_t                              rtag_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  output tag_t                              rtag_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  input  logic [AddrWidth-1:0]              wr_addr_i,
  input  logic [DataWidth-1:0]              wr_data_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  output logic [NumReadPorts*AddrWidth-1:0] mem_req_addr_o,
  output logic [NumReadPorts-1:0]           mem_req_valid_o,
  input  logic [NumReadPorts-1:0]           mem_req_ready_i,
  input  logic [NumReadPorts*DataWidth-1:0] mem_rsp_data_i,
  input  logic [NumReadPorts-1:0]           mem_rsp_valid_i,
  output logic [AddrWidth-1:0]              mem_wr_addr_o,
  output logic [DataWidth-1:0]              mem_wr_data_o,
  output logic                              mem_wr_valid_o,
  input  logic                              mem_wr_ready_i
);
  localparam int unsigned N  = NumReadPorts;
  localparam int unsigned DW = DataWidth;
  localparam int unsigned AW = AddrWidth;
  localparam int unsigned PW = $clog2(MaxOutstanding);
  localparam int unsigned CW = PW + 1;

  logic [N-1:0][AW-1:0] iss_addr;
  logic [N-1:0]         iss_pend, req_fire, fwd_mask, need, have, head_fwd;
  logic [N-1:0][DW-1:0] f_head;
  logic [DW-1:0]        head_fdata;
  logic                 accept, pop, iss_free, full;
  logic [PW-1:0]        t_wp, t_rp;
  logic [CW-1:0]        t_cnt;
  tag_t                 t_tag [MaxOutstanding];
  logic [N-1:0]         t_en  [MaxOutstanding];

  assign mem_wr_addr_o  = wr_addr_i;
  assign mem_wr_data_o  = wr_data_i;
  assign mem_wr_valid_o = wr_valid_i;
  assign wr_ready_o     = mem_wr_ready_i;

  assign req_fire        = iss_pend & mem_req_ready_i;
  assign iss_free        = (iss_pend & ~req_fire) == '0;
  assign full            = t_cnt == CW'(MaxOutstanding);
  assign rready_o        = iss_free & ~full;
  assign accept          = rvalid_i & rready_o;
  assign mem_req_valid_o = iss_pend;
  assign mem_req_addr_o  = iss_addr;

`ifdef SNITCH_VFPR_MP_FWD_EN
  logic [N-1:0]  t_fwd   [MaxOutstanding];
  logic [DW-1:0] t_fdata [MaxOutstanding];
  // Enabled ports reading the address written this cycle take the write data
  always_comb begin
    fwd_mask = '0;
    for (int i = 0; i < N; i++)
      fwd_mask[i] = ren_i[i] & wr_valid_i & mem_wr_ready_i & (raddr_i[i*AW +: AW] == wr_addr_i);
  end
  // Forward mask and data travel with the bundle in the tracker
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < MaxOutstanding; k++) begin
        t_fwd[k]   <= '0;
        t_fdata[k] <= '0;
      end
    end else if (accept) begin
      t_fwd[t_wp]   <= fwd_mask;
      t_fdata[t_wp] <= wr_data_i;
    end
  end
  assign head_fwd   = t_fwd[t_rp];
  assign head_fdata = t_fdata[t_rp];
`else
  assign fwd_mask   = '0;
  assign head_fwd   = '0;
  assign head_fdata = '0;
`endif

  // Issue register: per-port pending bits clear as each request handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_pend <= '0;
      iss_addr <= '0;
    end else if (accept) begin
      iss_pend <= ren_i & ~fwd_mask;
      iss_addr <= raddr_i;
    end else begin
      iss_pend <= iss_pend & ~req_fire;
    end
  end

  // Bundle tracker: circular buffer holding tag and enables in acceptance order
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_wp  <= '0;
      t_rp  <= '0;
      t_cnt <= '0;
      for (int k = 0; k < MaxOutstanding; k++) begin
        t_tag[k] <= '0;
        t_en[k]  <= '0;
      end
    end else begin
      if (accept) begin
        t_tag[t_wp] <= rtag_i;
        t_en[t_wp]  <= ren_i;
        t_wp        <= t_wp + PW'(1);
      end
      if (pop) t_rp <= t_rp + PW'(1);
      t_cnt <= t_cnt + CW'(accept) - CW'(pop);
    end
  end

  assign need     = t_en[t_rp] & ~head_fwd;
  assign rvalid_o = (t_cnt != '0) & ((need & ~have) == '0);
  assign pop      = rvalid_o & rready_i;
  assign rtag_o   = (t_cnt != '0) ? t_tag[t_rp] : '0;

  // Assemble head bundle data: forwarded, queued response, or zero if disabled
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N; i++)
      if (t_cnt != '0 && t_en[t_rp][i])
        rdata_o[i*DW +: DW] = head_fwd[i] ? head_fdata : f_head[i];
  end

  for (genvar p = 0; p < N; p++) begin : g_rsp
    logic [DW-1:0] mem [MaxOutstanding];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          pop_p;
    assign pop_p     = pop & need[p];
    assign have[p]   = cnt != '0;
    assign f_head[p] = mem[rp];
    // Per-port in-order response queue, always accepts memory responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        for (int k = 0; k < MaxOutstanding; k++) mem[k] <= '0;
      end else begin
        if (mem_rsp_valid_i[p]) begin
          mem[wp] <= mem_rsp_data_i[p*DW +: DW];
          wp      <= wp + PW'(1);
        end
        if (pop_p) rp <= rp + PW'(1);
        cnt <= cnt + CW'(mem_rsp_valid_i[p]) - CW'(pop_p);
      end
    end
  end
endmodule

// File: tb/tb_snitch_vfpr_mp.sv
// tb_snitch_vfpr_mp: directed bench for snitch_vfpr_mp with a 1-cycle memory model
module tb_snitch_vfpr_mp;
  localparam int N = 3, DW = 64, AW = 8, MO = 4;
  typedef logic [3:0] tag_t;

  logic clk = 0, rst_n = 0;
  logic [N*AW-1:0] raddr = '0;
  logic [N-1:0] ren = '0;
  tag_t rtag = '0, rtag_o;
  logic rvalid_i = 0, rready_o, rvalid_o, rready_i = 0;
  logic [N*DW-1:0] rdata;
  logic [AW-1:0] wr_addr = '0, mw_addr;
  logic [DW-1:0] wr_data = '0, mw_data;
  logic wr_valid = 0, wr_ready, mw_valid, mw_ready = 1;
  logic [N*AW-1:0] mreq_addr;
  logic [N-1:0] mreq_valid, mreq_ready = '1, mrsp_valid;
  logic [N*DW-1:0] mrsp_data;
  int n_checks = 0, n_errors = 0;
  int req_cnt [N] = '{0, 0, 0};
  int c0, c1, c2;

  snitch_vfpr_mp #(.NumReadPorts(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO), .tag_t(tag_t)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(raddr), .ren_i(ren), .rtag_i(rtag), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_o(rdata), .rtag_o(rtag_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .mem_req_addr_o(mreq_addr), .mem_req_valid_o(mreq_valid), .mem_req_ready_i(mreq_ready),
    .mem_rsp_data_i(mrsp_data), .mem_rsp_valid_i(mrsp_valid),
    .mem_wr_addr_o(mw_addr), .mem_wr_data_o(mw_data), .mem_wr_valid_o(mw_valid), .mem_wr_ready_i(mw_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_val(input logic [7:0] a);
    return (a < 8'd4) ? (64'hA0 | {56'h0, a}) : {56'h0, a[3:0], a[3:0]};
  endfunction

  // Memory model: one-cycle read latency per port, cleared by the same reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrsp_valid <= '0;
      mrsp_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mrsp_valid[i] <= mreq_valid[i] & mreq_ready[i];
        mrsp_data[i*DW +: DW] <= mem_val(mreq_addr[i*AW +: AW]);
      end
    end
  end

  // Request handshake counters per port
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rst_n && mreq_valid[i] && mreq_ready[i]) req_cnt[i] <= req_cnt[i] + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input logic [3:0] t, input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
    int k = 0;
    #1;
    while (!rvalid_o && k < 20) begin
      nxt();
      #1;
      k++;
    end
    check({tag, "_seen"}, 64'(rvalid_o), 64'd1);
    if (rvalid_o) begin
      check({tag, "_tag"}, 64'(rtag_o), 64'(t));
      check({tag, "_d0"}, rdata[63:0], d0);
      check({tag, "_d1"}, rdata[127:64], d1);
      check({tag, "_d2"}, rdata[191:128], d2);
    end
    nxt();
  endtask

  initial begin
    #1;
    check("rst_rready", 64'(rready_o), 64'd1);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_req", 64'(mreq_valid), 64'd0);
    check("rst_rdata", 64'(|rdata), 64'd0);
    check("rst_rtag", 64'(rtag_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Single bundle, full latency profile
    nxt(); raddr = {8'd3, 8'd2, 8'd1}; ren = 3'b111; rtag = 4'd5; rvalid_i = 1; rready_i = 1; #1;
    check("t1_rready", 64'(rready_o), 64'd1);
    nxt(); rvalid_i = 0; #1;
    check("t1_req_valid", 64'(mreq_valid), 64'd7);
    check("t1_req_addr", 64'(mreq_addr), 64'h030201);
    check("t1_n1_rvalid", 64'(rvalid_o), 64'd0);
    nxt(); #1;
    check("t1_n2_rvalid", 64'(rvalid_o), 64'd0);
    check("t1_n2_req", 64'(mreq_valid), 64'd0);
    nxt(); #1;
    check("t1_n3_rvalid", 64'(rvalid_o), 64'd1);
    check("t1_tag", 64'(rtag_o), 64'd5);
    check("t1_d0", rdata[63:0], 64'hA1);
    check("t1_d1", rdata[127:64], 64'hA2);
    check("t1_d2", rdata[191:128], 64'hA3);
    nxt(); #1;
    check("t1_after", 64'(rvalid_o), 64'd0);

    // Single enabled port
    nxt(); raddr = {8'd0, 8'd7, 8'd0}; ren = 3'b010; rtag = 4'd2; rvalid_i = 1; #1;
    check("t2_rready", 64'(rready_o), 64'd1);
    nxt(); rvalid_i = 0; #1;
    check("t2_req_valid", 64'(mreq_valid), 64'd2);
    check("t2_req_addr1", 64'(mreq_addr[15:8]), 64'd7);
    wait_out("t2", 4'd2, 64'd0, 64'h77, 64'd0);

    // Tracker fill with output back-pressure
    rready_i = 0;
    for (int k = 0; k < 5; k++) begin
      nxt(); raddr = {3{8'(k)}}; ren = 3'b111; rtag = 4'(8 + k); rvalid_i = 1; #1;
      check("t3_rready", 64'(rready_o), 64'(k < 4));
    end
    for (int j = 0; j < 3; j++) begin
      nxt(); #1;
      check("t3_hold_rready", 64'(rready_o), 64'd0);
      check("t3_hold_valid", 64'(rvalid_o), 64'd1);
      check("t3_hold_tag", 64'(rtag_o), 64'd8);
      check("t3_hold_data", rdata[63:0], 64'hA0);
    end
    nxt(); rready_i = 1; #1;
    check("t3_no_bypass", 64'(rready_o), 64'd0);
    check("t3_tag8", 64'(rtag_o), 64'd8);
    nxt(); #1;
    check("t3_reopen", 64'(rready_o), 64'd1);
    check("t3_tag9", 64'(rtag_o), 64'd9);
    check("t3_d9", rdata[127:64], 64'hA1);
    nxt(); rvalid_i = 0;
    wait_out("t3_b2", 4'd10, 64'hA2, 64'hA2, 64'hA2);
    wait_out("t3_b3", 4'd11, 64'hA3, 64'hA3, 64'hA3);
    wait_out("t3_b4", 4'd12, 64'h44, 64'h44, 64'h44);

    // Memory request stall on port 2
    c0 = req_cnt[0]; c1 = req_cnt[1]; c2 = req_cnt[2];
    nxt(); mreq_ready = 3'b011; raddr = {8'd3, 8'd2, 8'd1}; ren = 3'b111; rtag = 4'd3; rvalid_i = 1; #1;
    check("t4_rready", 64'(rready_o), 64'd1);
    nxt(); rvalid_i = 0; #1;
    check("t4_req_n1", 64'(mreq_valid), 64'd7);
    check("t4_busy", 64'(rready_o), 64'd0);
    nxt(); #1;
    check("t4_req_n2", 64'(mreq_valid), 64'd4);
    nxt(); #1;
    check("t4_req_n3", 64'(mreq_valid), 64'd4);
    check("t4_wait_out", 64'(rvalid_o), 64'd0);
    nxt(); mreq_ready = 3'b111; #1;
    check("t4_req_n4", 64'(mreq_valid), 64'd4);
    check("t4_freeing", 64'(rready_o), 64'd1);
    wait_out("t4", 4'd3, 64'hA1, 64'hA2, 64'hA3);
    check("t4_cnt0", 64'(req_cnt[0] - c0), 64'd1);
    check("t4_cnt1", 64'(req_cnt[1] - c1), 64'd1);
    check("t4_cnt2", 64'(req_cnt[2] - c2), 64'd1);

    // Write pass-through and same-cycle read of the written address
    nxt(); raddr = {8'd0, 8'd0, 8'd4}; ren = 3'b001; rtag = 4'd6; rvalid_i = 1;
    wr_addr = 8'd4; wr_data = 64'hDEAD; wr_valid = 1; mw_ready = 1; #1;
    check("t5_rready", 64'(rready_o), 64'd1);
    check("t5_wr_addr", 64'(mw_addr), 64'd4);
    check("t5_wr_data", mw_data, 64'hDEAD);
    check("t5_wr_valid", 64'(mw_valid), 64'd1);
    check("t5_wr_ready", 64'(wr_ready), 64'd1);
    nxt(); rvalid_i = 0; wr_valid = 0; mw_ready = 0; #1;
    check("t5_wr_ready_lo", 64'(wr_ready), 64'd0);
    check("t5_wr_valid_lo", 64'(mw_valid), 64'd0);
`ifdef SNITCH_VFPR_MP_FWD_EN
    check("t5_req", 64'(mreq_valid), 64'd0);
    wait_out("t5", 4'd6, 64'hDEAD, 64'd0, 64'd0);
`else
    check("t5_req", 64'(mreq_valid), 64'd1);
    wait_out("t5", 4'd6, 64'h44, 64'd0, 64'd0);
`endif
    mw_ready = 1;

    // Reset with bundles in flight
    rready_i = 0;
    nxt(); raddr = {8'd1, 8'd2, 8'd3}; ren = 3'b111; rtag = 4'd1; rvalid_i = 1;
    nxt(); rtag = 4'd2;
    nxt(); rvalid_i = 0;
    nxt(); #1;
    check("t6_inflight", 64'(rvalid_o), 64'd1);
    rst_n = 0; #1;
    check("t6_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("t6_rst_rready", 64'(rready_o), 64'd1);
    check("t6_rst_req", 64'(mreq_valid), 64'd0);
    check("t6_rst_tag", 64'(rtag_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    nxt(); #1;
    check("t6_post_rvalid", 64'(rvalid_o), 64'd0);
    rready_i = 1; raddr = {8'd3, 8'd2, 8'd1}; ren = 3'b111; rtag = 4'd7; rvalid_i = 1; #1;
    check("t6_rready", 64'(rready_o), 64'd1);
    nxt(); rvalid_i = 0;
    wait_out("t6", 4'd7, 64'hA1, 64'hA2, 64'hA3);
    nxt(); #1;
    check("t6_drained", 64'(rvalid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
